// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: write-back port arbiter for the 32x32 register file.
// Merges the in-order pipeline result with an auxiliary (mul/div) result
// stream. Auxiliary results wait in a small circular queue. A pipeline write
// always wins the port. A pipeline write to register R invalidates every
// queued entry for R, so a stale aux result can never overwrite a newer value.
// Optional macro WB_FWD_EN adds a combinational forwarding lookup over
// uncommitted writes. Without it, FwdHit/FwdData are tied to 0.
module reg_wb_arbiter #(
  parameter int AUX_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PipeValid,
  input  logic [4:0]  PipeWrAddr,
  input  logic [31:0] PipeWrData,
  input  logic        AuxValid,
  input  logic [4:0]  AuxWrAddr,
  input  logic [31:0] AuxWrData,
  output logic        AuxReady,
  output logic        RegWrite,
  output logic [4:0]  RegWrAddr,
  output logic [31:0] RegWrData,
  input  logic [4:0]  FwdAddr,
  output logic        FwdHit,
  output logic [31:0] FwdData
);

  localparam int PW = (AUX_DEPTH > 1) ? $clog2(AUX_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(AUX_DEPTH);

  // queue storage
  logic [AUX_DEPTH-1:0]        r_vld;
  logic [AUX_DEPTH-1:0][4:0]   r_addr;
  logic [AUX_DEPTH-1:0][31:0]  r_data;
  logic [PW-1:0]               r_wptr;
  logic [PW-1:0]               r_rptr;
  logic [CW-1:0]               r_count;

  // registered write port
  logic        r_wr;
  logic [4:0]  r_wr_addr;
  logic [31:0] r_wr_data;

  logic w_pipe_sel;
  logic w_push;
  logic w_pop;
  logic w_push_vld;

  // Ready reflects registered occupancy only. A same-cycle pop does not free a slot.
  assign AuxReady   = (r_count < DEPTH_C) && !Rst;
  assign w_pipe_sel = PipeValid && (PipeWrAddr != 5'd0);
  assign w_push     = AuxValid && AuxReady;
  assign w_pop      = !w_pipe_sel && (r_count != '0);
  // A push is stored invalid for r0, or when it is shadowed by a same-edge pipe write.
  assign w_push_vld = (AuxWrAddr != 5'd0) &&
                      !(w_pipe_sel && (AuxWrAddr == PipeWrAddr));

  assign RegWrite  = r_wr;
  assign RegWrAddr = r_wr_addr;
  assign RegWrData = r_wr_data;

  // Output port arbitration: pipe first, then queue head, else idle with held addr/data.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wr      <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_pipe_sel) begin
      r_wr      <= 1'b1;
      r_wr_addr <= PipeWrAddr;
      r_wr_data <= PipeWrData;
    end else if (w_pop) begin
      r_wr      <= r_vld[r_rptr];
      r_wr_addr <= r_addr[r_rptr];
      r_wr_data <= r_data[r_rptr];
    end else begin
      r_wr      <= 1'b0;
    end
  end

  // Queue entries. Push a new entry, clear the popped head, and cancel entries shadowed by a pipe write.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_vld  <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      for (int i = 0; i < AUX_DEPTH; i++) begin
        if (w_push && (r_wptr == PW'(i))) begin
          r_vld[i]  <= w_push_vld;
          r_addr[i] <= AuxWrAddr;
          r_data[i] <= AuxWrData;
        end else if (w_pop && (r_rptr == PW'(i))) begin
          r_vld[i]  <= 1'b0;
        end else if (w_pipe_sel && (r_addr[i] == PipeWrAddr)) begin
          r_vld[i]  <= 1'b0;
        end
      end
    end
  end

  // Pointers wrap naturally because the depth is a power of two. Count tracks push minus pop.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef WB_FWD_EN
  logic          w_fwd_hit;
  logic [31:0]   w_fwd_data;
  logic [PW-1:0] w_fidx;

  // Walk the queue from oldest to youngest so the youngest match wins. Fall back to the output register.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_fidx     = '0;
    if (FwdAddr != 5'd0) begin
      for (int k = 0; k < AUX_DEPTH; k++) begin
        w_fidx = r_rptr + PW'(k);
        if ((CW'(k) < r_count) && r_vld[w_fidx] && (r_addr[w_fidx] == FwdAddr)) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = r_data[w_fidx];
        end
      end
      if (!w_fwd_hit && r_wr && (r_wr_addr == FwdAddr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wr_data;
      end
    end
  end

  assign FwdHit  = w_fwd_hit;
  assign FwdData = w_fwd_data;
`else
  logic [4:0] w_fwd_unused;
  assign w_fwd_unused = FwdAddr;
  assign FwdHit  = 1'b0;
  assign FwdData = '0;
`endif

endmodule
